muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 14 +
 rtl/muldiv_seq.sv | 82 ++++++++
 2 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared divider FSM encodings and handshake constants
package muldiv_seq_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam int DoubleRegBus = 64;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle restoring radix-2 divider (signed/unsigned) with annul and stall handshake
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);
  div_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] q, r, d;
  logic a_neg, b_neg, go, neg;
  logic [2*DATA_W-1:0] res;
  logic [DATA_W:0] sh;
  logic [DATA_W+1:0] diff;
  assign go = start_i & ~annul_i;
  assign sh = {r, q[DATA_W-1]};
  assign diff = {1'b0, sh} - {2'b0, d};
  assign neg = diff[DATA_W+1];
  assign ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o = ready_o ? res : '0;
  assign stallreq_o = start_i & ~ready_o & ~annul_i & ~rst;
  always_comb begin
    state_n = state;
    unique case (state)
      DivFree:   state_n = !go ? DivFree : (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_n = annul_i ? DivFree : DivEnd;
      DivOn:     state_n = annul_i ? DivFree : (cnt == LAST) ? DivEnd : DivOn;
      DivEnd:    state_n = (annul_i || start_i == DivStop) ? DivFree : DivEnd;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DivFree;
    else state <= state_n;
  end
  // cnt == LAST is the extra ON cycle that applies sign correction on the way into END
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      res <= '0;
    end else begin
      unique case (state)
        DivFree: if (go) begin
          a_neg <= signed_div_i & opdata1_i[DATA_W-1];
          b_neg <= signed_div_i & opdata2_i[DATA_W-1];
          q <= (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
          d <= (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
          r <= '0;
          cnt <= '0;
        end
        DivByZero: res <= '0;
        DivOn: if (!annul_i) begin
          if (cnt != LAST) begin
            r <= neg ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
            q <= {q[DATA_W-2:0], ~neg};
            cnt <= cnt + 1'b1;
          end else begin
            res <= {a_neg ? -r : r, (a_neg ^ b_neg) ? -q : q};
            cnt <= '0;
          end
        end
        DivEnd: ;
      endcase
    end
  end
endmodule
